// File: rtl/uart_rx_deserializer.sv
// UART receive front end: 16x oversampled 8N1/8E1/8O1 deserializer that pushes
// {break, framing, parity, data[7:0]} words into the receive FIFO.
module uart_rx_deserializer #(
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        baud_tick,
   input  logic        rx,
   input  logic        parity_en,
   input  logic        parity_odd,
   input  logic        fifo_full,
   input  logic        overrun_clr,
   output logic        rx_wr_en,
   output logic [10:0] rx_data,
   output logic        overrun,
   output logic        busy
);

   localparam int unsigned TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TAP_A     = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TAP_B     = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] TAP_C     = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic xor8(input logic [7:0] d);
      return ^d;
   endfunction

   logic          rx_meta_q, rx_sync_q;
   state_e        state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          s7_q, s7_d, s8_q, s8_d;
   logic          armed_q, armed_d;
   logic          par_en_q, par_en_d, par_odd_q, par_odd_d;
   logic          par_bit_q, par_bit_d, par_err_q, par_err_d;
   logic          wr_en_q, wr_en_d;
   logic [10:0]   data_q, data_d;
   logic          overrun_q, overrun_d;
   logic          busy_q, busy_d;

   logic [TW-1:0] tick_idx_s;
   logic          maj_s, fe_s, pe_s, brk_s, overrun_set_s;

   // Two-flop synchronizer for the asynchronous serial line, idle-high reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   assign tick_idx_s = tick_cnt_q + TW'(1);
   assign maj_s      = maj3(s7_q, s8_q, rx_sync_q);
   assign fe_s       = ~maj_s;
   assign pe_s       = par_en_q & par_err_q;
   assign brk_s      = fe_s & (shreg_q == 8'h00) & (~par_en_q | ~par_bit_q);

   // Next-state and output decode; everything but the strobe holds between ticks.
   always_comb begin
      state_d       = state_q;
      tick_cnt_d    = tick_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      shreg_d       = shreg_q;
      s7_d          = s7_q;
      s8_d          = s8_q;
      armed_d       = armed_q;
      par_en_d      = par_en_q;
      par_odd_d     = par_odd_q;
      par_bit_d     = par_bit_q;
      par_err_d     = par_err_q;
      wr_en_d       = 1'b0;
      data_d        = data_q;
      overrun_set_s = 1'b0;

      if (baud_tick) begin
         if (state_q != ST_IDLE) begin
            tick_cnt_d = tick_idx_s;
         end else begin
            tick_cnt_d = tick_cnt_q;
         end
         if (tick_idx_s == TAP_A) begin
            s7_d = rx_sync_q;
         end else if (tick_idx_s == TAP_B) begin
            s8_d = rx_sync_q;
         end else begin
            s7_d = s7_q;
         end

         case (state_q)
            ST_IDLE: begin
               if (armed_q && !rx_sync_q) begin
                  state_d    = ST_START;
                  tick_cnt_d = {TW{1'b0}};
               end else if (!armed_q && rx_sync_q) begin
                  armed_d = 1'b1;
               end else begin
                  armed_d = armed_q;
               end
            end
            ST_START: begin
               if (tick_idx_s == TAP_C && maj_s) begin
                  state_d = ST_IDLE;
               end else if (tick_idx_s == TICK_LAST) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'd0;
                  par_en_d  = parity_en;
                  par_odd_d = parity_odd;
                  par_bit_d = 1'b0;
                  par_err_d = 1'b0;
               end else begin
                  state_d = ST_START;
               end
            end
            ST_DATA: begin
               if (tick_idx_s == TAP_C) begin
                  shreg_d = {maj_s, shreg_q[7:1]};
               end else if (tick_idx_s == TICK_LAST) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = par_en_q ? ST_PARITY : ST_STOP;
                  end else begin
                     state_d = ST_DATA;
                  end
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_PARITY: begin
               if (tick_idx_s == TAP_C) begin
                  par_bit_d = maj_s;
                  par_err_d = (xor8(shreg_q) ^ maj_s) != par_odd_q;
               end else if (tick_idx_s == TICK_LAST) begin
                  state_d = ST_STOP;
               end else begin
                  state_d = ST_PARITY;
               end
            end
            ST_STOP: begin
               // The word is committed mid stop bit so a back-to-back start is not missed.
               if (tick_idx_s == TAP_C) begin
                  state_d = ST_IDLE;
                  armed_d = maj_s;
                  if (!fifo_full) begin
                     wr_en_d = 1'b1;
                     data_d  = {brk_s, fe_s, pe_s, shreg_q};
                  end else begin
                     overrun_set_s = 1'b1;
                  end
               end else begin
                  state_d = ST_STOP;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      if (overrun_set_s) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered-output update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= {TW{1'b0}};
         bit_cnt_q  <= 3'd0;
         shreg_q    <= 8'h00;
         s7_q       <= 1'b1;
         s8_q       <= 1'b1;
         armed_q    <= 1'b1;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         par_bit_q  <= 1'b0;
         par_err_q  <= 1'b0;
         wr_en_q    <= 1'b0;
         data_q     <= 11'h000;
         overrun_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         s7_q       <= s7_d;
         s8_q       <= s8_d;
         armed_q    <= armed_d;
         par_en_q   <= par_en_d;
         par_odd_q  <= par_odd_d;
         par_bit_q  <= par_bit_d;
         par_err_q  <= par_err_d;
         wr_en_q    <= wr_en_d;
         data_q     <= data_d;
         overrun_q  <= overrun_d;
         busy_q     <= busy_d;
      end
   end

   assign rx_wr_en = wr_en_q;
   assign rx_data  = data_q;
   assign overrun  = overrun_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: table-driven frames plus
// hand-written corner sequences, with a queue scoreboard on the FIFO push.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

   typedef struct {
      logic [7:0]  data;
      logic        pen;
      logic        podd;
      logic        pbit;
      logic        stop;
      logic [10:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, baud_tick, rx, parity_en, parity_odd, fifo_full, overrun_clr;
   logic        rx_wr_en, overrun, busy;
   logic [10:0] rx_data;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          tb_ticks = 0;
   int          strobes = 0;
   int          last_strobe_tick = 0;
   int          t0, s0;
   logic [10:0] exp_q[$];
   vec_t        vecs[9];

   uart_rx_deserializer #(.OVERSAMPLE(16)) dut (
      .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx),
      .parity_en(parity_en), .parity_odd(parity_odd), .fifo_full(fifo_full),
      .overrun_clr(overrun_clr), .rx_wr_en(rx_wr_en), .rx_data(rx_data),
      .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (baud_tick) tb_ticks <= tb_ticks + 1;
   end

   // One-clk baud tick every fourth clock.
   initial begin
      baud_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         baud_tick = 1'b1;
         @(negedge clk);
         baud_tick = 1'b0;
      end
   end

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!baud_tick) @(posedge clk);
      end
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                             input logic stop);
      rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         wait_ticks(16);
      end
      if (pen) begin
         rx = pbit;
         wait_ticks(16);
      end
      rx = stop;
      wait_ticks(16);
      rx = 1'b1;
   endtask

   initial begin
      vecs[0] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 11'h13C};
      vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 11'h03C};
      vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 11'h03C};
      vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 11'h255};
      vecs[4] = '{8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 11'h012};
      vecs[5] = '{8'hF0, 1'b1, 1'b1, 1'b1, 1'b1, 11'h0F0};
      vecs[6] = '{8'hE0, 1'b1, 1'b1, 1'b1, 1'b1, 11'h1E0};
      vecs[7] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 11'h600};
      vecs[8] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 11'h080};

      reset = 1'b0; rx = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
      fifo_full = 1'b0; overrun_clr = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (rx_wr_en) begin
               strobes++;
               last_strobe_tick = tb_ticks;
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_strobe: got rx_data=0x%0h, required no push", rx_data);
               end else begin
                  check("rx_data", rx_data, exp_q.pop_front());
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      check("reset_wr_en", rx_wr_en, 0);
      check("reset_data", rx_data, 0);
      check("reset_overrun", overrun, 0);
      check("reset_busy", busy, 0);
      reset = 1'b1;
      wait_ticks(4);

      // 0xA5 8N1: stop decision 153 ticks after START entry, strobe one clk later.
      exp_q.push_back(11'h0A5);
      t0 = tb_ticks; s0 = strobes;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      wait_ticks(2);
      check("a5_strobes", strobes - s0, 1);
      check("a5_latency_ticks", last_strobe_tick - t0, 154);
      check("a5_busy_after", busy, 0);

      for (int i = 0; i < 9; i++) begin
         parity_en  = vecs[i].pen;
         parity_odd = vecs[i].podd;
         exp_q.push_back(vecs[i].exp);
         s0 = strobes;
         send_frame(vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].stop);
         wait_ticks(3);
         check($sformatf("vec%0d_strobes", i), strobes - s0, 1);
      end

      // Break: line low for 20 bit times yields exactly one word.
      parity_en = 1'b0;
      exp_q.push_back(11'h600);
      s0 = strobes;
      rx = 1'b0;
      wait_ticks(320);
      check("break_strobes", strobes - s0, 1);
      check("break_busy", busy, 0);
      rx = 1'b1;
      wait_ticks(4);
      check("break_no_second", strobes - s0, 1);

      // Short glitch is a false start.
      s0 = strobes;
      rx = 1'b0;
      wait_ticks(5);
      rx = 1'b1;
      wait_ticks(30);
      check("glitch_strobes", strobes - s0, 0);
      check("glitch_busy", busy, 0);

      // Overrun with FIFO full, then clear.
      fifo_full = 1'b1;
      s0 = strobes;
      send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
      wait_ticks(2);
      check("ovr_strobes", strobes - s0, 0);
      check("ovr_flag", overrun, 1);
      check("ovr_data_held", rx_data, 11'h600);
      fifo_full = 1'b0;
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      check("ovr_cleared", overrun, 0);

      // Reset during data bit 4 aborts the frame.
      wait_ticks(4);
      rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 4; i++) begin
         rx = i[0];
         wait_ticks(16);
      end
      rx = 1'b1;
      wait_ticks(8);
      check("midframe_busy", busy, 1);
      reset = 1'b0;
      #1;
      check("rst_mid_wr_en", rx_wr_en, 0);
      check("rst_mid_data", rx_data, 0);
      check("rst_mid_overrun", overrun, 0);
      check("rst_mid_busy", busy, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      wait_ticks(4);
      exp_q.push_back(11'h081);
      s0 = strobes;
      send_frame(8'h81, 1'b0, 1'b0, 1'b1);
      wait_ticks(4);
      check("post_reset_strobes", strobes - s0, 1);

      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive-side front end of the UART. Takes the asynchronous serial `rx` line, oversamples it with the shared 16x baud tick, and recovers 8N1/8E1/8O1 frames. Each completed frame is pushed into the receive FIFO as one 11-bit word: 8 data bits plus parity, framing and break error flags. A single-cycle write strobe carries the push, and the block flags overrun when the FIFO is full.

## Interface
- `OVERSAMPLE`, 16: baud ticks per bit; fixed at 16 (mid-bit taps at ticks 7/8/9).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `baud_tick` in 1: one-`clk` pulse at 16x baud rate.
- `rx` in 1: serial input, asynchronous, idle high.
- `parity_en` in 1: 1 = frame carries a parity bit after data.
- `parity_odd` in 1: 1 = odd parity, 0 = even; ignored when `parity_en`=0.
- `fifo_full` in 1: receive FIFO full.
- `overrun_clr` in 1: one-cycle clear of `overrun`.
- `rx_wr_en` out 1: one-`clk` push strobe to the FIFO.
- `rx_data` out 11: [7:0] data (LSB received first), [8] parity_err, [9] framing_err, [10] break_err.
- `overrun` out 1: sticky; a frame was dropped because `fifo_full`=1.
- `busy` out 1: 1 whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value.
- State, tick counter and bit counter advance only on `baud_tick`.
- Bit value is the majority of the samples at ticks 7, 8 and 9 of the bit. The decision is made at tick 9.

FSM:
- **IDLE**
  - Requires `armed`=1 (the synchronized rx has been seen high since the last frame).
  - On a tick with rx=0, go to START with tick_cnt=0.
- **START**
  - At tick 9, majority=1 means a false start: return to IDLE with no output.
  - At tick 15, go to DATA with tick_cnt=0 and bit_cnt=0.
- **DATA**
  - At tick 9, shift the majority into shreg[7] (right shift, LSB first).
  - At tick 15, increment bit_cnt. After bit 7, go to PARITY if `parity_en`, else STOP.
- **PARITY**
  - At tick 9, parity_err = (XOR of data bits and parity bit) != `parity_odd`.
  - At tick 15, go to STOP.
  - parity_err=0 when `parity_en`=0.
- **STOP**
  - At tick 9, framing_err = ~majority.
  - break_err = framing_err & (data==0) & (parity bit==0 or `parity_en`=0).
  - Latch the word and go to IDLE immediately; the remainder of the stop bit is not waited for.
  - If framing_err=1, clear `armed`. Re-arm on the first tick with synced rx=1.

Output on the stop decision:
- If `fifo_full`=0: `rx_wr_en`=1 for exactly one `clk` and `rx_data` is updated.
- If `fifo_full`=1: no strobe, `rx_data` is unchanged, and `overrun` is set.

Additional rules:
- `overrun_clr` clears `overrun`. If a set and a clear coincide in the same cycle, set wins.
- `parity_en` and `parity_odd` are sampled at the START→DATA transition and held for the whole frame.
- Reset values:
  - `rx_wr_en`=0, `rx_data`=0, `overrun`=0, `busy`=0.
  - FSM=IDLE, `armed`=1.
  - Synchronizer flops=1.
- Reset asserted mid-frame aborts the frame. No strobe is issued and the partial data is discarded.

## Timing
- Synchronizer latency: 2 `clk`.
- `rx_wr_en` rises in the `clk` cycle after the `baud_tick` carrying the stop-bit tick-9 decision.
- `rx_data` is valid in the same cycle as `rx_wr_en` and held until the next push.
- Measured from the START-entry tick, the stop decision falls on tick 153 without parity and tick 169 with parity.
- `busy` rises on the START-entry tick and falls on the stop decision.
- Back-to-back frames:
  - The next start edge may arrive from stop tick 10 onward and is detected on the first subsequent tick.
  - A minimum inter-frame gap is not required.
- No `baud_tick` means no state change. Gaps between ticks of any length are legal.

## Test plan
- Frame 0xA5, 8N1, `fifo_full`=0 → one `rx_wr_en` pulse with `rx_data`=0x0A5, arriving 153 ticks after START entry; `busy` low afterwards.
- 0x3C with even parity enabled but parity bit sent as 1 → `rx_data`=0x13C. Repeat with a correct parity bit of 0 → 0x03C. Odd parity with bit 1 → 0x03C.
- 0x55 with stop bit driven 0 then line returned high → `rx_data`=0x255. A following frame 0x12 is received as 0x012.
- Line held low for 20 bit times, no parity → one word 0x600. No second word until rx returns high and a new start arrives.
- Glitches and overrun:
  - rx low for 5 ticks only → no `rx_wr_en`, FSM back in IDLE.
  - Frame 0x7E with `fifo_full`=1 → no strobe, `overrun`=1, `rx_data` unchanged.
  - `overrun_clr` pulse → `overrun`=0.
- `reset` asserted (0) during data bit 4 of a frame → all outputs at reset values immediately. After release and a fresh frame 0x81, exactly one word 0x081 is pushed.
